hps_cmd_decoder: RTL and testbench

Parametrised HPS-to-fabric command decoder that replaces the ad-hoc opcode/byte-assembly logic in the top level. It accepts 8-bit writes from the HPS lightweight bridge and assembles them into three commands: render-queue entries, sprite-pixel loads and queue clears. It drives the render FIFO through a valid/ready handshake instead of a blind write pulse, tracks field completeness, and exposes a readable status/error register. All logic runs on posedge clk; no negedge processes.

---
 rtl/hps_cmd_pkg.sv | 17 +
 rtl/hps_byte_assembler.sv | 33 +++
 rtl/hps_cmd_decoder.sv | 98 +++++++++
 tb/tb_hps_cmd_decoder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hps_cmd_pkg.sv
// hps_cmd_pkg: opcode defaults, register indices and status/control bit positions for hps_cmd_decoder
package hps_cmd_pkg;
  localparam logic [7:0] OP_LOAD_DEF = 8'hFD;
  localparam logic [7:0] OP_CLEAR_DEF = 8'hFE;
  localparam logic [3:0] REG_STATUS = 4'd0;
  localparam logic [3:0] REG_COUNT = 4'd1;
  localparam logic [3:0] REG_OP = 4'd2;
  localparam logic [3:0] REG_CTRL = 4'd15;
  localparam int ST_VALID = 0;
  localparam int ST_INCOMPLETE = 1;
  localparam int ST_OVERFLOW = 2;
  localparam int CTRL_CLR_ERR = 0;
  localparam int CTRL_CLR_CNT = 1;
  function automatic int bytes_of(input int bits);
    return (bits + 7) / 8;
  endfunction
endpackage

// File: rtl/hps_byte_assembler.sv
// hps_byte_assembler: NB-byte MSB-first field register (idx 0 = MSB); merged = contents incl. this write, complete = all bytes seen incl. this write
module hps_byte_assembler #(
  parameter int NB = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic          clr,
  input  logic [3:0]    idx,
  input  logic [7:0]    din,
  output logic [NB*8-1:0] merged,
  output logic          complete
);
  logic [NB*8-1:0] data;
  logic [NB-1:0] mask, sel;
  always_comb begin
    sel = '0;
    merged = data;
    if (we && 32'(idx) < NB) begin
      sel = NB'(1) << idx;
      merged[(NB-1-32'(idx))*8 +: 8] = din;
    end
  end
  assign complete = &(mask | sel);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      data <= '0;
      mask <= '0;
    end else begin
      data <= merged;
      mask <= clr ? '0 : mask | sel;
    end
endmodule

// File: rtl/hps_cmd_decoder.sv
// hps_cmd_decoder: assembles HPS byte writes into render entries (rq valid/ready), pixel loads (pix_*) and clear pulses; status/count/op readable
module hps_cmd_decoder import hps_cmd_pkg::*; #(
  parameter int RENDER_W = 48,
  parameter int PIX_W = 24,
  parameter int PIX_ADDR_W = 20,
  parameter logic [7:0] OP_LOAD = OP_LOAD_DEF,
  parameter logic [7:0] OP_CLEAR = OP_CLEAR_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hps_chipselect,
  input  logic                  hps_write,
  input  logic                  hps_read,
  input  logic [3:0]            hps_address,
  input  logic [7:0]            hps_writedata,
  output logic [7:0]            hps_readdata,
  output logic                  rq_valid,
  input  logic                  rq_ready,
  output logic [RENDER_W-1:0]   rq_data,
  output logic                  pix_we,
  output logic [PIX_ADDR_W-1:0] pix_addr,
  output logic [PIX_W-1:0]      pix_data,
  output logic                  clear
);
  localparam int NR = RENDER_W / 8;
  localparam int NL = PIX_W / 8 + bytes_of(PIX_ADDR_W);
  logic [7:0] op, cnt, status, rd_mux;
  logic err_inc, err_ov, wr, op_wr, ctrl, is_load, is_clr, is_rnd;
  logic r_we, r_commit, r_done, l_we, l_commit, l_done, c_commit, clr_mask;
  logic rnd_ok, ld_ok, inc, ov, accepted;
  logic [(NR-1)*8-1:0] r_merged;
  logic [NL*8-1:0] l_merged;
  assign wr = hps_chipselect && hps_write;
  assign op_wr = wr && hps_address == REG_STATUS;
  assign ctrl = wr && hps_address == REG_CTRL;
  assign is_load = op == OP_LOAD;
  assign is_clr = op == OP_CLEAR;
  assign is_rnd = !is_load && !is_clr;
  assign r_we = wr && is_rnd && hps_address != 4'd0 && 32'(hps_address) <= NR - 1;
  assign r_commit = r_we && 32'(hps_address) == NR - 1;
  assign l_we = wr && is_load && hps_address != 4'd0 && 32'(hps_address) <= NL;
  assign l_commit = l_we && 32'(hps_address) == NL;
  assign c_commit = wr && is_clr && hps_address != 4'd0 && hps_address != REG_CTRL;
  assign clr_mask = op_wr || r_commit || l_commit || c_commit;
  // A handshake in the commit cycle frees the slot, so the new entry is taken rather than dropped.
  assign rnd_ok = r_commit && r_done && (!rq_valid || rq_ready);
  assign ld_ok = l_commit && l_done;
  assign inc = (r_commit && !r_done) || (l_commit && !l_done);
  assign ov = r_commit && r_done && rq_valid && !rq_ready;
  assign accepted = rnd_ok || ld_ok || c_commit;
  hps_byte_assembler #(.NB(NR - 1)) u_rnd (
    .clk(clk), .reset(reset), .we(r_we), .clr(clr_mask), .idx(hps_address - 4'd1),
    .din(hps_writedata), .merged(r_merged), .complete(r_done)
  );
  hps_byte_assembler #(.NB(NL)) u_pix (
    .clk(clk), .reset(reset), .we(l_we), .clr(clr_mask), .idx(hps_address - 4'd1),
    .din(hps_writedata), .merged(l_merged), .complete(l_done)
  );
  always_comb begin
    status = '0;
    status[ST_VALID] = rq_valid;
    status[ST_INCOMPLETE] = err_inc;
    status[ST_OVERFLOW] = err_ov;
    rd_mux = hps_address == REG_STATUS ? status :
             hps_address == REG_COUNT ? cnt :
             hps_address == REG_OP ? op : 8'h00;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      op <= '0;
      cnt <= '0;
      err_inc <= 1'b0;
      err_ov <= 1'b0;
      rq_valid <= 1'b0;
      rq_data <= '0;
      pix_we <= 1'b0;
      pix_addr <= '0;
      pix_data <= '0;
      clear <= 1'b0;
      hps_readdata <= '0;
    end else begin
      if (op_wr) op <= hps_writedata;
      if (op_wr && !rq_valid && hps_writedata != OP_LOAD && hps_writedata != OP_CLEAR)
        rq_data[RENDER_W-1 -: 8] <= hps_writedata;
      if (rnd_ok) rq_data <= {op, r_merged};
      rq_valid <= c_commit ? 1'b0 : rnd_ok ? 1'b1 : rq_valid && !rq_ready;
      pix_we <= ld_ok;
      if (ld_ok) begin
        pix_data <= l_merged[NL*8-1 -: PIX_W];
        pix_addr <= PIX_ADDR_W'(l_merged[bytes_of(PIX_ADDR_W)*8-1:0]);
      end
      clear <= c_commit;
      err_inc <= inc || (err_inc && !(ctrl && hps_writedata[CTRL_CLR_ERR]));
      err_ov <= ov || (err_ov && !(ctrl && hps_writedata[CTRL_CLR_ERR]));
      cnt <= (ctrl && hps_writedata[CTRL_CLR_CNT] ? 8'h00 : cnt) + {7'b0, accepted};
      if (hps_chipselect && hps_read) hps_readdata <= rd_mux;
    end
endmodule

// File: tb/tb_hps_cmd_decoder.sv
// tb_hps_cmd_decoder: scoreboard bench for hps_cmd_decoder at default parameters
module tb_hps_cmd_decoder;
  logic clk = 0, reset = 1, hps_chipselect = 0, hps_write = 0, hps_read = 0, rq_ready = 0;
  logic [3:0] hps_address = 0;
  logic [7:0] hps_writedata = 0, hps_readdata, rv;
  logic rq_valid, pix_we, clear;
  logic [47:0] rq_data;
  logic [19:0] pix_addr;
  logic [23:0] pix_data;
  int total = 0, bad = 0, exp_cnt = 0, clr_seen = 0;
  logic [47:0] rq_q[$];
  logic [43:0] pix_q[$];
  always #10 clk = ~clk;
  hps_cmd_decoder dut (
    .clk(clk), .reset(reset), .hps_chipselect(hps_chipselect), .hps_write(hps_write),
    .hps_read(hps_read), .hps_address(hps_address), .hps_writedata(hps_writedata),
    .hps_readdata(hps_readdata), .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_data(rq_data),
    .pix_we(pix_we), .pix_addr(pix_addr), .pix_data(pix_data), .clear(clear)
  );
  always @(negedge clk) begin
    if (!reset && rq_valid && rq_ready) begin
      total++;
      if (rq_q.size() == 0) begin
        bad++;
        $display("FAIL rq_handshake unexpected entry got=%h", rq_data);
      end else begin
        logic [47:0] e;
        e = rq_q.pop_front();
        if (rq_data !== e) begin
          bad++;
          $display("FAIL rq_data got=%h exp=%h", rq_data, e);
        end
      end
    end
    if (!reset && pix_we) begin
      total++;
      if (pix_q.size() == 0) begin
        bad++;
        $display("FAIL pix_we unexpected addr=%h data=%h", pix_addr, pix_data);
      end else begin
        logic [43:0] e;
        e = pix_q.pop_front();
        if ({pix_addr, pix_data} !== e) begin
          bad++;
          $display("FAIL pix_write got=%h exp=%h", {pix_addr, pix_data}, e);
        end
      end
    end
    if (clear) clr_seen++;
  end
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk); #1 hps_chipselect = 1; hps_write = 1; hps_address = a; hps_writedata = d;
    @(posedge clk); #1 hps_chipselect = 0; hps_write = 0;
  endtask
  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    @(posedge clk); #1 hps_chipselect = 1; hps_read = 1; hps_address = a;
    @(posedge clk); #1 hps_chipselect = 0; hps_read = 0;
    @(negedge clk); d = hps_readdata;
  endtask
  task automatic send_render(input logic [7:0] op, input logic [39:0] b, input int n);
    wr(4'd0, op);
    for (int i = 1; i <= n; i++) wr(4'(i), b[(5-i)*8 +: 8]);
  endtask
  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({rq_valid, rq_data, pix_we, pix_addr, pix_data, clear, hps_readdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", {rq_valid, rq_data, pix_we, pix_addr, pix_data, clear, hps_readdata});
    end
    reset = 0;
    rd(4'd2, rv);
    total++;
    if (rv !== 8'h00) begin bad++; $display("FAIL reset_op got=%h exp=00", rv); end
  endtask
  task automatic test_render;
    rq_ready = 1;
    rq_q.push_back(48'h03_1122334455);
    send_render(8'h03, 40'h1122334455, 5);
    exp_cnt++;
    @(negedge clk);
    total++;
    if (rq_valid !== 1'b1) begin bad++; $display("FAIL render_valid got=%b exp=1", rq_valid); end
    @(negedge clk);
    total++;
    if (rq_valid !== 1'b0) begin bad++; $display("FAIL render_valid_drop got=%b exp=0", rq_valid); end
    rd(4'd1, rv);
    total++;
    if (rv !== 8'(exp_cnt)) begin bad++; $display("FAIL render_count got=%h exp=%h", rv, 8'(exp_cnt)); end
  endtask
  task automatic test_overflow;
    rq_ready = 0;
    rq_q.push_back(48'h03_A1A2A3A4A5);
    send_render(8'h03, 40'hA1A2A3A4A5, 5);
    exp_cnt++;
    send_render(8'h03, 40'hB1B2B3B4B5, 5);
    rd(4'd0, rv);
    total++;
    if (rv !== 8'h05) begin bad++; $display("FAIL overflow_status got=%h exp=05", rv); end
    @(posedge clk); #1 rq_ready = 1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (rq_valid !== 1'b0) begin bad++; $display("FAIL overflow_drain got=%b exp=0", rq_valid); end
    wr(4'd15, 8'h01);
    rd(4'd0, rv);
    total++;
    if (rv !== 8'h00) begin bad++; $display("FAIL overflow_errclr got=%h exp=00", rv); end
    rd(4'd1, rv);
    total++;
    if (rv !== 8'(exp_cnt)) begin bad++; $display("FAIL overflow_count got=%h exp=%h", rv, 8'(exp_cnt)); end
  endtask
  task automatic test_back_to_back;
    rq_ready = 0;
    rq_q.push_back(48'h05_C1C2C3C4C5);
    send_render(8'h05, 40'hC1C2C3C4C5, 5);
    rq_q.push_back(48'h07_D1D2D3D4D5);
    send_render(8'h07, 40'hD1D2D3D4D5, 4);
    @(posedge clk); #1 hps_chipselect = 1; hps_write = 1; hps_address = 4'd5; hps_writedata = 8'hD5; rq_ready = 1;
    @(posedge clk); #1 hps_chipselect = 0; hps_write = 0;
    exp_cnt += 2;
    @(negedge clk);
    @(negedge clk);
    rd(4'd0, rv);
    total++;
    if (rv !== 8'h00) begin bad++; $display("FAIL b2b_status got=%h exp=00", rv); end
    total++;
    if (rq_q.size() != 0) begin bad++; $display("FAIL b2b_pending got=%0d exp=0", rq_q.size()); end
  endtask
  task automatic test_load;
    wr(4'd0, 8'hFD);
    wr(4'd1, 8'hAA); wr(4'd2, 8'hBB); wr(4'd3, 8'hCC); wr(4'd4, 8'h0F); wr(4'd5, 8'h12);
    pix_q.push_back({20'hF1234, 24'hAABBCC});
    wr(4'd6, 8'h34);
    exp_cnt++;
    @(negedge clk);
    total++;
    if (pix_we !== 1'b1) begin bad++; $display("FAIL load_we got=%b exp=1", pix_we); end
    @(negedge clk);
    total++;
    if ({pix_we, pix_addr} !== {1'b0, 20'hF1234}) begin
      bad++;
      $display("FAIL load_hold got=%h exp=%h", {pix_we, pix_addr}, {1'b0, 20'hF1234});
    end
  endtask
  task automatic test_incomplete;
    wr(4'd0, 8'hFD);
    wr(4'd1, 8'h01); wr(4'd3, 8'h03); wr(4'd4, 8'h04); wr(4'd5, 8'h05); wr(4'd6, 8'h06);
    @(negedge clk);
    rd(4'd0, rv);
    total++;
    if (rv !== 8'h02) begin bad++; $display("FAIL incomplete_status got=%h exp=02", rv); end
    wr(4'd15, 8'h01);
    rd(4'd0, rv);
    total++;
    if (rv !== 8'h00) begin bad++; $display("FAIL incomplete_errclr got=%h exp=00", rv); end
    rd(4'd1, rv);
    total++;
    if (rv !== 8'(exp_cnt)) begin bad++; $display("FAIL incomplete_count got=%h exp=%h", rv, 8'(exp_cnt)); end
  endtask
  task automatic test_clear;
    int c0;
    rq_ready = 0;
    rq_q.push_back(48'h09_E1E2E3E4E5);
    send_render(8'h09, 40'hE1E2E3E4E5, 5);
    rd(4'd0, rv);
    total++;
    if (rv !== 8'h01) begin bad++; $display("FAIL clear_pending got=%h exp=01", rv); end
    c0 = clr_seen;
    wr(4'd0, 8'hFE);
    wr(4'd1, 8'h00);
    rq_q.delete();
    exp_cnt += 2;
    @(negedge clk);
    total++;
    if ({clear, rq_valid} !== 2'b10) begin bad++; $display("FAIL clear_pulse got=%b exp=10", {clear, rq_valid}); end
    @(negedge clk);
    total++;
    if (clear !== 1'b0 || clr_seen - c0 != 1) begin
      bad++;
      $display("FAIL clear_width got=%0d pulses exp=1", clr_seen - c0);
    end
    rd(4'd1, rv);
    total++;
    if (rv !== 8'(exp_cnt)) begin bad++; $display("FAIL clear_count got=%h exp=%h", rv, 8'(exp_cnt)); end
    rq_ready = 1;
  endtask
  task automatic test_wrap;
    wr(4'd15, 8'h02);
    exp_cnt = 0;
    rd(4'd1, rv);
    total++;
    if (rv !== 8'h00) begin bad++; $display("FAIL cnt_clear got=%h exp=00", rv); end
    wr(4'd0, 8'hFE);
    for (int i = 0; i < 256; i++) wr(4'(1 + i % 14), 8'h00);
    rd(4'd1, rv);
    total++;
    if (rv !== 8'h00) begin bad++; $display("FAIL cnt_wrap got=%h exp=00", rv); end
    wr(4'd14, 8'h00);
    rd(4'd1, rv);
    total++;
    if (rv !== 8'h01) begin bad++; $display("FAIL cnt_after_wrap got=%h exp=01", rv); end
  endtask
  task automatic test_reset_mid;
    wr(4'd0, 8'hFD);
    wr(4'd1, 8'h11); wr(4'd2, 8'h22); wr(4'd3, 8'h33);
    @(negedge clk); reset = 1;
    rq_q.delete();
    pix_q.delete();
    exp_cnt = 0;
    @(negedge clk);
    total++;
    if ({rq_valid, rq_data, pix_we, pix_addr, pix_data, clear, hps_readdata} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs got=%h exp=0", {rq_valid, rq_data, pix_we, pix_addr, pix_data, clear, hps_readdata});
    end
    reset = 0;
    wr(4'd4, 8'h44); wr(4'd5, 8'h55); wr(4'd6, 8'h66);
    @(negedge clk);
    total++;
    if ({rq_valid, pix_we} !== 2'b00) begin bad++; $display("FAIL midreset_commit got=%b exp=00", {rq_valid, pix_we}); end
    rd(4'd0, rv);
    total++;
    if (rv !== 8'h02) begin bad++; $display("FAIL midreset_status got=%h exp=02", rv); end
    rd(4'd1, rv);
    total++;
    if (rv !== 8'h00) begin bad++; $display("FAIL midreset_count got=%h exp=00", rv); end
  endtask
  initial begin
    #2000000;
    $display("FAIL timeout bench did not finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    test_reset;
    test_render;
    test_overflow;
    test_back_to_back;
    test_load;
    test_incomplete;
    test_clear;
    test_wrap;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
